cpu_bus_arbiter: RTL

- Shares the single CPU memory bus between two requesters: A = instruction fetch (read-only, from the instruction cache) and B = data load/store (read/write).
- Each requester uses the cache-style handshake: hold request high, receive a one-cycle ready with rdata valid in that cycle.
- The block sits between the CPU front end and the system bus.
- It provides round-robin arbitration, a post-transfer release cycle, and a bus watchdog timeout.

---
 rtl/cpu_bus_arbiter_if.sv | 45 ++++
 rtl/cpu_bus_arbiter.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/cpu_bus_arbiter_if.sv
// Signal bundle between the two CPU requesters, the arbiter and the system bus.
// The slave modport is the arbiter's view; master is the requester/bus-model view.
interface cpu_bus_arbiter_if;
  logic        i_pa_request;
  logic [31:0] i_pa_address;
  logic        o_pa_ready;
  logic [31:0] o_pa_rdata;

  logic        i_pb_request;
  logic        i_pb_rw;
  logic [31:0] i_pb_address;
  logic [31:0] i_pb_wdata;
  logic        o_pb_ready;
  logic [31:0] o_pb_rdata;

  logic        o_bus_request;
  logic        o_bus_rw;
  logic [31:0] o_bus_address;
  logic [31:0] o_bus_wdata;
  logic        i_bus_ready;
  logic [31:0] i_bus_rdata;

  logic        o_timeout;
  logic        o_fault;

  modport slave (
    input  i_pa_request, i_pa_address,
    output o_pa_ready, o_pa_rdata,
    input  i_pb_request, i_pb_rw, i_pb_address, i_pb_wdata,
    output o_pb_ready, o_pb_rdata,
    output o_bus_request, o_bus_rw, o_bus_address, o_bus_wdata,
    input  i_bus_ready, i_bus_rdata,
    output o_timeout, o_fault
  );

  modport master (
    output i_pa_request, i_pa_address,
    input  o_pa_ready, o_pa_rdata,
    output i_pb_request, i_pb_rw, i_pb_address, i_pb_wdata,
    input  o_pb_ready, o_pb_rdata,
    input  o_bus_request, o_bus_rw, o_bus_address, o_bus_wdata,
    output i_bus_ready, i_bus_rdata,
    input  o_timeout, o_fault
  );
endinterface

// File: rtl/cpu_bus_arbiter.sv
// Round-robin arbiter sharing the CPU memory bus between instruction fetch (A)
// and data load/store (B), with a release cycle after every transfer and a bus watchdog.
module cpu_bus_arbiter #(
  parameter int TIMEOUT = 1023,
  parameter int TW      = 10
) (
  input  logic            i_clock,
  input  logic            i_reset,
  cpu_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2,
    RELEASE = 2'd3
  } state_e;

  localparam logic          PORT_A    = 1'b0;
  localparam logic          PORT_B    = 1'b1;
  localparam logic          WD_ENABLE = (TIMEOUT != 0);
  localparam logic [TW-1:0] WD_LAST   = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] WD_ONE    = TW'(1);
  localparam logic [TW-1:0] WD_ZERO   = TW'(0);

  state_e        state_r;
  state_e        next_state_s;
  logic          last_grant_r;
  logic          next_last_grant_s;
  logic [TW-1:0] wd_count_r;
  logic [TW-1:0] next_wd_count_s;
  logic          fault_r;
  logic          next_fault_s;

  logic          grant_a_s;
  logic          grant_b_s;
  logic          port_req_s;
  logic          wd_fire_s;
  logic          bus_request_s;
  logic          done_s;
  logic [31:0]   rdata_s;
  logic          timeout_s;

  assign grant_a_s  = (state_r == GRANT_A);
  assign grant_b_s  = (state_r == GRANT_B);
  assign port_req_s = grant_b_s ? bus.i_pb_request : bus.i_pa_request;
  assign wd_fire_s  = WD_ENABLE && (wd_count_r == WD_LAST);

  // State, grant history, watchdog counter and sticky fault registers.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_r      <= IDLE;
      last_grant_r <= PORT_B;
      wd_count_r   <= WD_ZERO;
      fault_r      <= 1'b0;
    end else begin
      state_r      <= next_state_s;
      last_grant_r <= next_last_grant_s;
      wd_count_r   <= next_wd_count_s;
      fault_r      <= next_fault_s;
    end
  end

  // Next-state logic: arbitration, completion, abort and watchdog expiry.
  always_comb begin
    next_state_s      = state_r;
    next_last_grant_s = last_grant_r;
    next_wd_count_s   = wd_count_r;
    next_fault_s      = fault_r;
    bus_request_s     = 1'b0;
    done_s            = 1'b0;
    rdata_s           = 32'h0000_0000;
    timeout_s         = 1'b0;

    case (state_r)
      IDLE: begin
        // On a tie the port that did not win last time goes next.
        if (bus.i_pa_request && (!bus.i_pb_request || (last_grant_r == PORT_B))) begin
          next_state_s      = GRANT_A;
          next_last_grant_s = PORT_A;
          next_wd_count_s   = WD_ZERO;
        end else if (bus.i_pb_request) begin
          next_state_s      = GRANT_B;
          next_last_grant_s = PORT_B;
          next_wd_count_s   = WD_ZERO;
        end else begin
          next_state_s      = IDLE;
        end
      end

      GRANT_A, GRANT_B: begin
        bus_request_s = port_req_s;
        if (!port_req_s) begin
          next_state_s = RELEASE;
        end else if (bus.i_bus_ready) begin
          done_s       = 1'b1;
          rdata_s      = bus.i_bus_rdata;
          next_state_s = RELEASE;
        end else if (wd_fire_s) begin
          done_s       = 1'b1;
          timeout_s    = 1'b1;
          next_fault_s = 1'b1;
          next_state_s = RELEASE;
        end else begin
          next_wd_count_s = wd_count_r + WD_ONE;
        end
      end

      RELEASE: begin
        next_state_s = IDLE;
      end

      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Output steering; reset forces every output low in the same cycle.
  always_comb begin
    if (i_reset) begin
      bus.o_bus_request = 1'b0;
      bus.o_bus_rw      = 1'b0;
      bus.o_bus_address = 32'h0000_0000;
      bus.o_bus_wdata   = 32'h0000_0000;
      bus.o_pa_ready    = 1'b0;
      bus.o_pa_rdata    = 32'h0000_0000;
      bus.o_pb_ready    = 1'b0;
      bus.o_pb_rdata    = 32'h0000_0000;
      bus.o_timeout     = 1'b0;
      bus.o_fault       = 1'b0;
    end else begin
      bus.o_bus_request = bus_request_s;
      bus.o_bus_rw      = grant_b_s ? bus.i_pb_rw : 1'b0;
      bus.o_bus_address = grant_b_s ? bus.i_pb_address :
                          (grant_a_s ? bus.i_pa_address : 32'h0000_0000);
      bus.o_bus_wdata   = grant_b_s ? bus.i_pb_wdata : 32'h0000_0000;
      bus.o_pa_ready    = done_s & grant_a_s;
      bus.o_pa_rdata    = (done_s & grant_a_s) ? rdata_s : 32'h0000_0000;
      bus.o_pb_ready    = done_s & grant_b_s;
      bus.o_pb_rdata    = (done_s & grant_b_s) ? rdata_s : 32'h0000_0000;
      bus.o_timeout     = timeout_s;
      bus.o_fault       = fault_r;
    end
  end

endmodule
